// File: rtl/targetc_axil_regs.sv
`default_nettype none
// ============================================================================
// targetc_axil_regs : AXI4-Lite responder with NUM_RW control registers
//                     (byte-strobed, write pulses) and NUM_RO status words.
// Revision 1.0 - initial release
// ============================================================================
module targetc_axil_regs #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 7,
   parameter int          NUM_RW             = 8,
   parameter int          NUM_RO             = 8,
   parameter logic [31:0] RW_RESET           = 32'h0000_0000
) (
   input  logic                                   S_AXI_ACLK,
   input  logic                                   S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                             S_AXI_AWPROT,
   input  logic                                   S_AXI_AWVALID,
   output logic                                   S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                                   S_AXI_WVALID,
   output logic                                   S_AXI_WREADY,
   output logic [1:0]                             S_AXI_BRESP,
   output logic                                   S_AXI_BVALID,
   input  logic                                   S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                             S_AXI_ARPROT,
   input  logic                                   S_AXI_ARVALID,
   output logic                                   S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                             S_AXI_RRESP,
   output logic                                   S_AXI_RVALID,
   input  logic                                   S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH*NUM_RW-1:0]   ctrl_regs,
   output logic [NUM_RW-1:0]                      ctrl_wr_pulse,
   input  logic [C_S_AXI_DATA_WIDTH*NUM_RO-1:0]   status_regs
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic            ready_en;
   logic            aw_full;
   logic            w_full;
   logic [IW-1:0]   aw_idx;
   logic [DW-1:0]   w_data;
   logic [DW/8-1:0] w_strb;
   logic [DW-1:0]   regs [NUM_RW];
   logic            commit;
   logic            aw_err;
   logic [IW-1:0]   ar_idx;
   logic [DW-1:0]   rd_word;
   logic            rd_err;
   logic            unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // ready_en keeps every ready low during reset and for the first edge after it
   assign S_AXI_AWREADY = ready_en && !aw_full;
   assign S_AXI_WREADY  = ready_en && !w_full;
   assign S_AXI_ARREADY = ready_en && !S_AXI_RVALID;

   assign aw_err = 32'(aw_idx) >= 32'(NUM_RW);
   assign commit = aw_full && w_full && (!S_AXI_BVALID || S_AXI_BREADY);
   assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

   generate
      for (genvar k = 0; k < NUM_RW; k++) begin : g_flat
         assign ctrl_regs[DW*k +: DW] = regs[k];
      end
   endgenerate

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         ready_en      <= 1'b0;
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         aw_idx        <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
         ctrl_wr_pulse <= '0;
         for (int k = 0; k < NUM_RW; k++) begin
            regs[k] <= RW_RESET;
         end
      end else begin
         ready_en      <= 1'b1;
         ctrl_wr_pulse <= '0;
         if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_full <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         end
         if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_full <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         // commit can only fire with both buffers full, so it never races a handshake
         if (commit) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= aw_err ? RESP_SLVERR : RESP_OKAY;
            for (int k = 0; k < NUM_RW; k++) begin
               if (32'(aw_idx) == k) begin
                  ctrl_wr_pulse[k] <= 1'b1;
                  for (int b = 0; b < DW/8; b++) begin
                     if (w_strb[b]) begin
                        regs[k][8*b +: 8] <= w_data[8*b +: 8];
                     end
                  end
               end
            end
         end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_word = '0;
      rd_err  = 1'b1;
      for (int k = 0; k < NUM_RW; k++) begin
         if (32'(ar_idx) == k) begin
            rd_word = regs[k];
            rd_err  = 1'b0;
         end
      end
      for (int k = 0; k < NUM_RO; k++) begin
         if (32'(ar_idx) == NUM_RW + k) begin
            rd_word = status_regs[DW*k +: DW];
            rd_err  = 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_word;
         S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_targetc_axil_regs.sv
`default_nettype none
// ============================================================================
// tb_targetc_axil_regs : vector table, directed corner cases and random traffic
//                        against an array-based register model.
// Revision 1.0 - initial release
// ============================================================================
module tb_targetc_axil_regs;
   localparam int NRW = 8;
   localparam int NRO = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [6:0]   awaddr, araddr;
   logic [2:0]   awprot, arprot;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [255:0] ctrl_regs;
   logic [7:0]   ctrl_wr_pulse;
   logic [255:0] status_regs;

   always #5 clk = ~clk;

   targetc_axil_regs dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .status_regs(status_regs)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] model_rw [NRW];
   logic [31:0] status_w [NRO];

   typedef struct packed {
      logic        is_wr;
      logic [6:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;
   vec_t vecs [$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: registers are a plain word array, decoded by word index
   function automatic logic [255:0] model_flat();
      logic [255:0] f;
      for (int k = 0; k < NRW; k++) f[32*k +: 32] = model_rw[k];
      return f;
   endfunction

   function automatic void model_write(input logic [6:0] addr, input logic [31:0] d, input logic [3:0] s,
                                       output logic [1:0] resp, output logic [7:0] pulse);
      int idx;
      idx   = int'(addr[6:2]);
      pulse = 8'h00;
      resp  = 2'b10;
      if (idx < NRW) begin
         for (int b = 0; b < 4; b++) if (s[b]) model_rw[idx][8*b +: 8] = d[8*b +: 8];
         pulse[idx] = 1'b1;
         resp       = 2'b00;
      end
   endfunction

   function automatic void model_read(input logic [6:0] addr, output logic [31:0] d, output logic [1:0] resp);
      int idx;
      idx  = int'(addr[6:2]);
      d    = 32'h0;
      resp = 2'b10;
      if (idx < NRW) begin
         d = model_rw[idx]; resp = 2'b00;
      end else if (idx < NRW + NRO) begin
         d = status_w[idx - NRW]; resp = 2'b00;
      end
   endfunction

   // Entered and left on a falling edge; each valid rises after its own delay
   task automatic push_aw_w(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      bit aw_hs, w_hs;
      int n = 0;
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done) && n < 50) begin
         if (!aw_done && n == aw_dly) awvalid = 1'b1;
         if (!w_done && n == w_dly) wvalid = 1'b1;
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge clk);
         n++;
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_handshake", {aw_done, w_done}, 2'b11);
   endtask

   task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
      logic [1:0] m_resp;
      logic [7:0] m_pulse;
      int lat = 0;
      push_aw_w(addr, data, strb, aw_dly, w_dly);
      while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
      check("wr_latency", lat, 1);
      model_write(addr, data, strb, m_resp, m_pulse);
      resp = bresp;
      check($sformatf("wr_bresp@%0h", addr), bresp, m_resp);
      check($sformatf("wr_pulse@%0h", addr), ctrl_wr_pulse, m_pulse);
      check($sformatf("ctrl_regs@%0h", addr), ctrl_regs, model_flat());
      @(negedge clk);
      check("wr_pulse_once", {bvalid, ctrl_wr_pulse}, 9'h000);
   endtask

   task automatic do_read(input logic [6:0] addr, output logic [31:0] data, output logic [1:0] resp);
      logic [31:0] m_d;
      logic [1:0]  m_r;
      bit hs = 1'b0;
      int n = 0;
      araddr = addr; arvalid = 1'b1;
      while (!hs && n < 50) begin
         hs = arvalid && arready;
         @(negedge clk);
         n++;
      end
      arvalid = 1'b0;
      check("rd_handshake", hs, 1);
      check("rd_latency", rvalid, 1);
      data = rdata; resp = rresp;
      model_read(addr, m_d, m_r);
      check($sformatf("rd_data@%0h", addr), rdata, m_d);
      check($sformatf("rd_resp@%0h", addr), rresp, m_r);
      @(negedge clk);
      check("rd_retire", rvalid, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      logic [7:0]  p;
      bit          hs;
      int          n;

      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 3'b010; arprot = 3'b010;
      for (int k = 0; k < NRW; k++) model_rw[k] = 32'h0;
      status_w[0] = 32'hCAFE_F00D;
      for (int k = 1; k < NRO; k++) status_w[k] = 32'h5000_0000 + 32'(k);
      for (int k = 0; k < NRO; k++) status_regs[32*k +: 32] = status_w[k];

      //            wr    addr   data          strb  exp_data      resp
      vecs.push_back('{1'b1, 7'h00, 32'h1,        4'hF, 32'h0,        2'b00});
      vecs.push_back('{1'b1, 7'h04, 32'h2,        4'hF, 32'h0,        2'b00});
      vecs.push_back('{1'b1, 7'h08, 32'h3,        4'hF, 32'h0,        2'b00});
      vecs.push_back('{1'b1, 7'h0C, 32'h4,        4'hF, 32'h0,        2'b00});
      vecs.push_back('{1'b0, 7'h00, 32'h0,        4'h0, 32'h1,        2'b00});
      vecs.push_back('{1'b0, 7'h04, 32'h0,        4'h0, 32'h2,        2'b00});
      vecs.push_back('{1'b0, 7'h08, 32'h0,        4'h0, 32'h3,        2'b00});
      vecs.push_back('{1'b0, 7'h0C, 32'h0,        4'h0, 32'h4,        2'b00});
      vecs.push_back('{1'b1, 7'h10, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00});
      vecs.push_back('{1'b1, 7'h10, 32'h000000AA, 4'h1, 32'h0,        2'b00});
      vecs.push_back('{1'b0, 7'h10, 32'h0,        4'h0, 32'hFFFFFFAA, 2'b00});
      vecs.push_back('{1'b0, 7'h20, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00});
      vecs.push_back('{1'b1, 7'h20, 32'hDEADBEEF, 4'hF, 32'h0,        2'b10});
      vecs.push_back('{1'b0, 7'h20, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00});
      vecs.push_back('{1'b1, 7'h40, 32'h12345678, 4'hF, 32'h0,        2'b10});
      vecs.push_back('{1'b0, 7'h40, 32'h0,        4'h0, 32'h0,        2'b10});
      vecs.push_back('{1'b0, 7'h0E, 32'h0,        4'h0, 32'h4,        2'b00});
      vecs.push_back('{1'b0, 7'h3C, 32'h0,        4'h0, 32'h50000007, 2'b00});
      vecs.push_back('{1'b0, 7'h7C, 32'h0,        4'h0, 32'h0,        2'b10});

      repeat (3) @(negedge clk);
      check("reset_ready_valid", {awready, wready, arready, bvalid, rvalid}, 5'b0);
      check("reset_resp_rdata", {bresp, rresp, rdata}, 36'h0);
      check("reset_ctrl", ctrl_regs, 256'h0);
      check("reset_pulse", ctrl_wr_pulse, 8'h0);
      rst_n = 1'b1;
      check("ready_at_release", {awready, wready, arready}, 3'b000);
      @(negedge clk);
      check("ready_after_release", {awready, wready, arready}, 3'b111);

      foreach (vecs[i]) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, r);
            check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
         end else begin
            do_read(vecs[i].addr, d, r);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
         end
      end

      // W leads AW by three cycles, then AW leads W; latency is checked inside
      do_write(7'h14, 32'hA5A5_0001, 4'hF, 3, 0, r);
      check("decoupled_w_first_resp", r, 2'b00);
      do_write(7'h18, 32'hA5A5_0002, 4'hF, 0, 3, r);
      check("decoupled_aw_first_resp", r, 2'b00);

      // Backpressure: first response held while a second write waits in the buffers
      bready = 1'b0;
      push_aw_w(7'h18, 32'h1111_2222, 4'hF, 0, 0);
      @(negedge clk);
      model_write(7'h18, 32'h1111_2222, 4'hF, r, p);
      check("bp_first_bvalid", {bvalid, bresp}, 3'b100);
      check("bp_first_pulse", ctrl_wr_pulse, p);
      push_aw_w(7'h1C, 32'h3333_4444, 4'hF, 0, 0);
      for (int c = 0; c < 10; c++) begin
         check($sformatf("bp_hold%0d_flags", c), {bvalid, bresp, awready, wready, ctrl_wr_pulse}, 13'b1_00_0_0_00000000);
         check($sformatf("bp_hold%0d_ctrl", c), ctrl_regs, model_flat());
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      model_write(7'h1C, 32'h3333_4444, 4'hF, r, p);
      check("bp_second_bvalid", {bvalid, bresp}, 3'b100);
      check("bp_second_pulse", ctrl_wr_pulse, p);
      check("bp_second_ctrl", ctrl_regs, model_flat());
      @(negedge clk);
      check("bp_retired", {bvalid, awready, wready}, 3'b011);

      // Random traffic against the model
      for (int i = 0; i < 60; i++) begin
         logic [6:0] a;
         if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(0, 127));
         else a = 7'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r);
         else
            do_read(a, d, r);
      end

      // Reset after the AW handshake, before any W
      do_write(7'h00, 32'h0BAD_CAFE, 4'hF, 0, 0, r);
      awaddr = 7'h04; awvalid = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < 20) begin
         hs = awready;
         @(negedge clk);
         n++;
      end
      awvalid = 1'b0;
      check("rst_aw_handshake", hs, 1);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NRW; k++) model_rw[k] = 32'h0;
      check("rst_async_ctrl", ctrl_regs, model_flat());
      check("rst_async_flags", {bvalid, rvalid, awready, wready, arready, ctrl_wr_pulse}, 13'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("rst_after%0d", c), {bvalid, ctrl_wr_pulse}, 9'h0);
      end
      check("rst_after_ctrl", ctrl_regs, 256'h0);
      do_read(7'h00, d, r);
      check("rst_read_back", d, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
